// File: rtl/ysyx_22040759_lsu.sv
// Load/store unit: one in-flight 8-byte-aligned data-memory access with lane shifting and load extension.
// Optional YSYX_22040759_LSU_MISALIGN_CHECK_EN: misaligned accesses complete at once with out_err=1 and no memory request.
module ysyx_22040759_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_wen,
   input  logic [2:0]  in_func3,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_wen,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic        out_err
);
   localparam int unsigned DW = 64;
   localparam int unsigned MW = 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   state_e          state_q, state_d;
   logic            wen_q, wen_d;
   logic [2:0]      func3_q, func3_d;
   logic [2:0]      off_q, off_d;
   logic            in_ready_q, in_ready_d;
   logic            mem_req_valid_q, mem_req_valid_d;
   logic [DW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [MW-1:0]   mem_wmask_q, mem_wmask_d;
   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_rdata_q, out_rdata_d;
   logic            out_err_q, out_err_d;
   logic            misalign_c;
   logic [DW-1:0]   shifted_c;
   logic [DW-1:0]   load_c;

   function automatic logic [MW-1:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

`ifdef YSYX_22040759_LSU_MISALIGN_CHECK_EN
   always_comb begin
      case (in_func3[1:0])
         2'b01:   misalign_c = in_addr[0];
         2'b10:   misalign_c = |in_addr[1:0];
         2'b11:   misalign_c = |in_addr[2:0];
         default: misalign_c = 1'b0;
      endcase
   end
`else
   assign misalign_c = 1'b0;
`endif

   // Bytes shifted past lane 7 are lost; upper bits read as zero before extension.
   always_comb begin
      shifted_c = mem_rdata >> {off_q, 3'b000};
      case (func3_q)
         3'b000:  load_c = {{56{shifted_c[7]}},  shifted_c[7:0]};
         3'b001:  load_c = {{48{shifted_c[15]}}, shifted_c[15:0]};
         3'b010:  load_c = {{32{shifted_c[31]}}, shifted_c[31:0]};
         3'b100:  load_c = {56'd0, shifted_c[7:0]};
         3'b101:  load_c = {48'd0, shifted_c[15:0]};
         3'b110:  load_c = {32'd0, shifted_c[31:0]};
         default: load_c = shifted_c;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wen_d       = wen_q;
      func3_d     = func3_q;
      off_d       = off_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      out_rdata_d = out_rdata_q;
      out_err_d   = out_err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               wen_d       = in_wen;
               func3_d     = in_func3;
               off_d       = in_addr[2:0];
               mem_addr_d  = {in_addr[63:3], 3'b000};
               mem_wdata_d = in_wdata << {in_addr[2:0], 3'b000};
               mem_wmask_d = size_mask(in_func3[1:0]) << in_addr[2:0];
               out_rdata_d = '0;
               out_err_d   = misalign_c;
               state_d     = misalign_c ? DONE : REQ;
            end
         end
         REQ: begin
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (mem_resp_valid) begin
               out_rdata_d = wen_q ? '0 : load_c;
               state_d     = DONE;
            end
         end
         default: begin
            if (out_ready) state_d = IDLE;
         end
      endcase
      in_ready_d      = (state_d == IDLE);
      mem_req_valid_d = (state_d == REQ);
      out_valid_d     = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         wen_q           <= 1'b0;
         func3_q         <= '0;
         off_q           <= '0;
         in_ready_q      <= 1'b1;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         mem_wmask_q     <= '0;
         out_valid_q     <= 1'b0;
         out_rdata_q     <= '0;
         out_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         wen_q           <= wen_d;
         func3_q         <= func3_d;
         off_q           <= off_d;
         in_ready_q      <= in_ready_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         mem_wmask_q     <= mem_wmask_d;
         out_valid_q     <= out_valid_d;
         out_rdata_q     <= out_rdata_d;
         out_err_q       <= out_err_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_wen       = wen_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wmask     = mem_wmask_q;
   assign out_valid     = out_valid_q;
   assign out_rdata     = out_rdata_q;
   assign out_err       = out_err_q;
endmodule

// File: tb/tb_ysyx_22040759_lsu.sv
// Directed self-checking bench for ysyx_22040759_lsu (honours YSYX_22040759_LSU_MISALIGN_CHECK_EN).
module tb_ysyx_22040759_lsu;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_wen;
   logic [2:0]  in_func3;
   logic [63:0] in_addr, in_wdata;
   logic        mem_req_valid, mem_req_ready, mem_wen;
   logic [63:0] mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_rdata;
   logic        out_valid, out_ready, out_err;
   logic [63:0] out_rdata;
   int          checks = 0;
   int          failures = 0;
   int          lat;

   ysyx_22040759_lsu dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
      .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request for a single cycle; DUT must be idle.
   task automatic issue(input logic wen, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
      in_valid = 1'b1; in_wen = wen; in_func3 = f3; in_addr = a; in_wdata = wd;
      step();
      in_valid = 1'b0; in_wdata = '0; in_addr = '0;
   endtask

   task automatic req_hs();
      mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
   endtask

   task automatic resp(input logic [63:0] rd);
      mem_resp_valid = 1'b1; mem_rdata = rd; step(); mem_resp_valid = 1'b0; mem_rdata = '0;
   endtask

   task automatic out_hs();
      out_ready = 1'b1; step(); out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_func3 = '0; in_addr = '0; in_wdata = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_wmask", 64'(mem_wmask), 64'd0);
      chk("rst_addr", mem_addr, 64'd0);
      chk("rst_rdata", out_rdata, 64'd0);

      // LB sign extension from lane 3
      issue(1'b0, 3'b000, 64'h8000_0003, 64'd0);
      chk("lb_req_valid", 64'(mem_req_valid), 64'd1);
      chk("lb_in_ready", 64'(in_ready), 64'd0);
      chk("lb_addr", mem_addr, 64'h8000_0000);
      chk("lb_wen", 64'(mem_wen), 64'd0);
      req_hs();
      chk("lb_wait_req_valid", 64'(mem_req_valid), 64'd0);
      resp(64'h0000_0000_80FF_0000);
      chk("lb_out_valid", 64'(out_valid), 64'd1);
      chk("lb_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_err", 64'(out_err), 64'd0);
      out_hs();
      chk("lb_back_in_ready", 64'(in_ready), 64'd1);

      // LBU, issued back-to-back
      issue(1'b0, 3'b100, 64'h8000_0003, 64'd0);
      req_hs(); resp(64'h0000_0000_80FF_0000);
      chk("lbu_rdata", out_rdata, 64'h0000_0000_0000_0080);
      out_hs();

      // SH to lanes 6-7
      issue(1'b1, 3'b001, 64'h8000_0006, 64'h1234);
      chk("sh_addr", mem_addr, 64'h8000_0000);
      chk("sh_wmask", 64'(mem_wmask), 64'hC0);
      chk("sh_wdata", mem_wdata, 64'h1234_0000_0000_0000);
      chk("sh_wen", 64'(mem_wen), 64'd1);
      req_hs(); resp(64'hDEAD_BEEF_DEAD_BEEF);
      chk("sh_out_valid", 64'(out_valid), 64'd1);
      chk("sh_rdata_zero", out_rdata, 64'd0);
      out_hs();

      // LW / LWU from upper word
      issue(1'b0, 3'b010, 64'h8000_0004, 64'd0);
      req_hs(); resp(64'h8765_4321_0000_0000);
      chk("lw_rdata", out_rdata, 64'hFFFF_FFFF_8765_4321);
      out_hs();
      issue(1'b0, 3'b110, 64'h8000_0004, 64'd0);
      req_hs(); resp(64'h8765_4321_0000_0000);
      chk("lwu_rdata", out_rdata, 64'h0000_0000_8765_4321);
      out_hs();

      // LD with 3-cycle req stall and 2-cycle out stall
      issue(1'b0, 3'b011, 64'h8000_0008, 64'd0);
      lat = 0;
      for (int i = 0; i < 3; i++) begin
         chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
         chk("stall_addr", mem_addr, 64'h8000_0008);
         step(); lat++;
      end
      req_hs(); lat++;
      resp(64'h1122_3344_5566_7788); lat++;
      for (int i = 0; i < 2; i++) begin
         chk("stall_out_valid", 64'(out_valid), 64'd1);
         chk("stall_out_rdata", out_rdata, 64'h1122_3344_5566_7788);
         step(); lat++;
      end
      chk("stall_out_valid_last", 64'(out_valid), 64'd1);
      out_hs(); lat++;
      chk("stall_latency", 64'(lat), 64'd8);
      chk("stall_done_out_valid", 64'(out_valid), 64'd0);
      chk("stall_done_in_ready", 64'(in_ready), 64'd1);

      // reset while waiting, then a stale response
      issue(1'b0, 3'b011, 64'h8000_0010, 64'd0);
      req_hs();
      rst = 1'b1; step(); rst = 1'b0;
      chk("rstw_in_ready", 64'(in_ready), 64'd1);
      chk("rstw_req_valid", 64'(mem_req_valid), 64'd0);
      resp(64'hFFFF_FFFF_FFFF_FFFF);
      chk("rstw_out_valid", 64'(out_valid), 64'd0);
      chk("rstw_in_ready2", 64'(in_ready), 64'd1);
      step();
      chk("rstw_out_valid2", 64'(out_valid), 64'd0);

`ifdef YSYX_22040759_LSU_MISALIGN_CHECK_EN
      issue(1'b1, 3'b010, 64'h8000_0002, 64'hAABB_CCDD);
      chk("mis_req_valid", 64'(mem_req_valid), 64'd0);
      chk("mis_out_valid", 64'(out_valid), 64'd1);
      chk("mis_out_err", 64'(out_err), 64'd1);
      chk("mis_rdata", out_rdata, 64'd0);
      out_hs();
      chk("mis_in_ready", 64'(in_ready), 64'd1);
      issue(1'b0, 3'b000, 64'h8000_0007, 64'd0);
      chk("mis_lb_req_valid", 64'(mem_req_valid), 64'd1);
      req_hs(); resp(64'h7F00_0000_0000_0000);
      chk("mis_lb_err", 64'(out_err), 64'd0);
      chk("mis_lb_rdata", out_rdata, 64'h7F);
      out_hs();
`else
      issue(1'b1, 3'b010, 64'h8000_0002, 64'hAABB_CCDD);
      chk("sw_mis_req_valid", 64'(mem_req_valid), 64'd1);
      chk("sw_mis_wmask", 64'(mem_wmask), 64'h3C);
      chk("sw_mis_wdata", mem_wdata, 64'h0000_AABB_CCDD_0000);
      req_hs(); resp(64'd0);
      chk("sw_mis_err", 64'(out_err), 64'd0);
      out_hs();
      // SD spilling past lane 7 drops the upper bytes
      issue(1'b1, 3'b011, 64'h8000_0005, 64'h1122_3344_5566_7788);
      chk("sd_spill_wmask", 64'(mem_wmask), 64'hE0);
      chk("sd_spill_wdata", mem_wdata, 64'h6677_8800_0000_0000);
      req_hs(); resp(64'd0); out_hs();
      // LD offset 5 reads zeros above bit 63
      issue(1'b0, 3'b011, 64'h8000_0005, 64'd0);
      req_hs(); resp(64'h1122_3344_5566_7788);
      chk("ld_spill_rdata", out_rdata, 64'h0000_0000_0011_2233);
      out_hs();
      // LH offset 7: high byte reads 0 so no sign extension
      issue(1'b0, 3'b001, 64'h8000_0007, 64'd0);
      req_hs(); resp(64'h8000_0000_0000_0000);
      chk("lh_spill_rdata", out_rdata, 64'h0000_0000_0000_0080);
      out_hs();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
